prog_seq_ctrl: RTL and testbench

Sequencer/control unit for the team's 4-entry x 2-bit instruction ROM. It drives the ROM selects from a 2-bit program counter, fetches and decodes the returned opcode, and executes it against an internal accumulator with an overflow flag. It sits between the instruction ROM and the top-level run control, and exposes run status and architectural state for observation.

---
 rtl/prog_seq_pkg.sv | 16 +
 rtl/prog_seq_alu.sv | 14 +
 rtl/prog_seq_ctrl.sv | 104 ++++++++++
 tb/tb_prog_seq_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared opcode encodings and FSM state type for the instruction-ROM sequencer.
package prog_seq_pkg;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/prog_seq_alu.sv
// Accumulator incrementer: next value plus carry-out from the top bit.
module prog_seq_alu #(
  parameter int unsigned ACC_W = 4
) (
  input  logic [ACC_W-1:0] acc_in,
  output logic [ACC_W-1:0] acc_out,
  output logic             carry_out
);

  always_comb begin
    {carry_out, acc_out} = {1'b0, acc_in} + (ACC_W+1)'(1);
  end

endmodule

// File: rtl/prog_seq_ctrl.sv
// Fetch/execute sequencer for the 4 x 2-bit instruction ROM with accumulator,
// overflow flag and saturating retired-instruction counter.
module prog_seq_ctrl
  import prog_seq_pkg::*;
#(
  parameter int unsigned ACC_W      = 4,
  parameter int unsigned CNT_W      = 8,
  parameter logic [1:0]  JNO_TARGET = 2'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             rom_sel1,
  output logic             rom_sel2,
  input  logic             rom_msb,
  input  logic             rom_lsb,
  output logic [1:0]       pc,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e             state_q, state_d;
  logic [1:0]         pc_q, pc_d;
  logic [1:0]         ir_q, ir_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_inc;
  logic               ovf_q, ovf_d, inc_carry;
  logic [CNT_W-1:0]   ret_q, ret_d;

  prog_seq_alu #(.ACC_W(ACC_W)) u_alu (
    .acc_in    (acc_q),
    .acc_out   (acc_inc),
    .carry_out (inc_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    ret_d   = ret_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          ret_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d    = {rom_msb, rom_lsb};
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        ret_d   = (ret_q == '1) ? ret_q : ret_q + CNT_W'(1);
        state_d = ST_FETCH;
        case (ir_q)
          OP_INC: begin
            acc_d = acc_inc;
            ovf_d = inc_carry;
            pc_d  = pc_q + 2'd1;
          end
          OP_JNO:  pc_d = ovf_q ? pc_q + 2'd1 : JNO_TARGET;
          OP_HLT:  state_d = ST_HALT;
          default: pc_d = pc_q + 2'd1;  // reserved opcode runs as NOP
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rom_sel1 = pc_q[0];
  assign rom_sel2 = pc_q[1];
  assign pc       = pc_q;
  assign acc      = acc_q;
  assign ovf      = ovf_q;
  assign retired  = ret_q;
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Scoreboard bench: an instruction-level model pushes per-instruction expected
// state at start; each retired instruction pops and compares.
module tb_prog_seq_ctrl;

  localparam int unsigned ACC_W   = 4;
  localparam int unsigned ACC_MAX = 15;
  localparam int unsigned JNO_T   = 0;

  typedef struct {
    int unsigned pc;
    int unsigned acc;
    int unsigned ovf;
    int unsigned ret;
    bit          halt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [1:0] rom [4];

  logic       a_sel1, a_sel2, a_msb, a_lsb, a_ovf, a_busy, a_halted;
  logic [1:0] a_pc;
  logic [3:0] a_acc;
  logic [7:0] a_ret;
  logic       b_sel1, b_sel2, b_msb, b_lsb, b_ovf, b_busy, b_halted;
  logic [1:0] b_pc;
  logic [3:0] b_acc;
  logic [1:0] b_ret;
  logic [1:0] a_word, b_word;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t tr_q[$];
  exp_t fin_q[$];

  always #5 clk = ~clk;

  assign a_word = rom[{a_sel2, a_sel1}];
  assign b_word = rom[{b_sel2, b_sel1}];
  assign a_msb  = a_word[1];
  assign a_lsb  = a_word[0];
  assign b_msb  = b_word[1];
  assign b_lsb  = b_word[0];

  prog_seq_ctrl #(.ACC_W(ACC_W), .CNT_W(8), .JNO_TARGET(2'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_sel1(a_sel1), .rom_sel2(a_sel2), .rom_msb(a_msb), .rom_lsb(a_lsb),
    .pc(a_pc), .acc(a_acc), .ovf(a_ovf), .busy(a_busy), .halted(a_halted),
    .retired(a_ret)
  );

  prog_seq_ctrl #(.ACC_W(ACC_W), .CNT_W(2), .JNO_TARGET(2'd0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_sel1(b_sel1), .rom_sel2(b_sel2), .rom_msb(b_msb), .rom_lsb(b_lsb),
    .pc(b_pc), .acc(b_acc), .ovf(b_ovf), .busy(b_busy), .halted(b_halted),
    .retired(b_ret)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction-level reference: runs the ROM program until HLT (bounded).
  function automatic void model_push(input int unsigned cnt_max, input bit to_trace);
    int unsigned p = 0, a = 0, o = 0, r = 0;
    logic [1:0] op;
    exp_t e;
    e = '{pc: 0, acc: 0, ovf: 0, ret: 0, halt: 1'b0};
    for (int s = 0; s < 300; s++) begin
      op = rom[p];
      e.halt = 1'b0;
      case (op)
        2'b00: begin
          if (a == ACC_MAX) begin a = 0; o = 1; end
          else begin a = a + 1; o = 0; end
          p = (p + 1) % 4;
        end
        2'b01:   p = (o != 0) ? (p + 1) % 4 : JNO_T;
        2'b10:   e.halt = 1'b1;
        default: p = (p + 1) % 4;
      endcase
      if (r < cnt_max) r = r + 1;
      e.pc = p; e.acc = a; e.ovf = o; e.ret = r;
      if (to_trace) tr_q.push_back(e);
      if (e.halt) break;
    end
    if (!to_trace) fin_q.push_back(e);
  endfunction

  task automatic run_prog(input bit poke_busy);
    exp_t e;
    int unsigned n, ncyc;
    tr_q.delete();
    fin_q.delete();
    model_push(255, 1'b1);
    model_push(3, 1'b0);
    n = tr_q.size();
    ncyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", a_busy, 1);
    check("retired_cleared", a_ret, 0);
    while (tr_q.size() > 0) begin
      if (poke_busy) start = 1'b1;
      @(negedge clk);
      ncyc++;
      @(negedge clk);
      ncyc++;
      start = 1'b0;
      e = tr_q.pop_front();
      check("pc", a_pc, e.pc);
      check("rom_sel", {a_sel2, a_sel1}, e.pc);
      check("acc", a_acc, e.acc);
      check("ovf", a_ovf, e.ovf);
      check("retired", a_ret, e.ret);
      check("halted", a_halted, e.halt);
      check("busy", a_busy, !e.halt);
    end
    check("halt_cycles", ncyc, 2 * n);
    e = fin_q.pop_front();
    check("sat_pc", b_pc, e.pc);
    check("sat_acc", b_acc, e.acc);
    check("sat_retired", b_ret, e.ret);
    check("sat_halted", b_halted, 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_pc", a_pc, 0);
    check("rst_acc", a_acc, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_retired", a_ret, 0);
    check("rst_busy", a_busy, 0);
    check("rst_halted", a_halted, 0);
    check("rst_sel", {a_sel2, a_sel1}, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", a_busy, 0);

    // Main program: INC, JNO, INC, HLT; then a restart from HALT with start poked while busy.
    rom[0] = 2'b00; rom[1] = 2'b01; rom[2] = 2'b00; rom[3] = 2'b10;
    run_prog(1'b0);
    check("final_acc", a_acc, 1);
    check("final_retired", a_ret, 34);
    run_prog(1'b1);
    check("rerun_acc", a_acc, 1);
    check("rerun_retired", a_ret, 34);

    // Abort during EXEC of the 5th instruction.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy", a_busy, 1);
    check("abort_retired_pre", a_ret, 4);
    rst_n = 1'b0;
    #1;
    check("abort_pc", a_pc, 0);
    check("abort_acc", a_acc, 0);
    check("abort_ovf", a_ovf, 0);
    check("abort_retired", a_ret, 0);
    check("abort_busy_low", a_busy, 0);
    check("abort_halted", a_halted, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_abort_busy", a_busy, 0);
    check("post_abort_halted", a_halted, 0);

    // Reserved opcodes run as NOPs before the halt.
    rom[0] = 2'b11; rom[1] = 2'b11; rom[2] = 2'b10; rom[3] = 2'b00;
    run_prog(1'b0);
    check("rsv_pc", a_pc, 2);
    check("rsv_acc", a_acc, 0);
    check("rsv_retired", a_ret, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
